// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_pkg
// Description : Shared widths, WB control bit indices and register count
//               for the write-back stage and its register file.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int RADDR_W  = 5;
  localparam int PTR_W    = 8;
  localparam int CNT_W    = 16;
  localparam int NUM_REGS = 1 << RADDR_W;

  // Bit positions inside the 3-bit WB control field
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_PTRUPD   = 2;

endpackage : wb_regfile_pkg
`default_nettype wire

// File: rtl/wb_regfile_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : 32 x 64 register storage, two combinational read ports,
//               one synchronous write port, r0 hardwired to zero and a
//               synchronous clear on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w
  import wb_regfile_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [RADDR_W-1:0] raddr1,
  input  logic [RADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]  rdata1,
  output logic [DATA_W-1:0]  rdata2
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  // Clear the whole array on reset, otherwise commit writes to r1..r31
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read ports: index 0 always reads as zero regardless of array contents
  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : r_mem[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : r_mem[raddr2];
  end

endmodule : regfile_2r1w
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Pipeline write-back stage. Selects ALU or load data, commits
//               it to the register file, holds the committed FIFO first/last
//               pointers and counts retired register writes.
//               Optional macro REGFILE_BYPASS_EN: write-through bypass so a
//               read of the register being written returns the new value in
//               the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [RADDR_W-1:0] wb_wreg,
  input  logic [DATA_W-1:0]  wb_aluout,
  input  logic [DATA_W-1:0]  wb_memdata,
  input  logic [2:0]         wb_ctrl,
  input  logic [PTR_W-1:0]   first_in,
  input  logic [PTR_W-1:0]   last_in,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0]  rs1_data,
  output logic [DATA_W-1:0]  rs2_data,
  output logic [DATA_W-1:0]  wb_data,
  output logic [PTR_W-1:0]   fifo_first,
  output logic [PTR_W-1:0]   fifo_last,
  output logic [CNT_W-1:0]   retire_cnt
);

  logic              w_commit;
  logic [DATA_W-1:0] w_rf_rd1;
  logic [DATA_W-1:0] w_rf_rd2;
  logic [PTR_W-1:0]  r_first;
  logic [PTR_W-1:0]  r_last;
  logic [CNT_W-1:0]  r_retire;

  // Write-back data select and the qualified commit strobe (r0 and reset excluded)
  always_comb begin
    wb_data  = wb_ctrl[CTRL_MEMTOREG] ? wb_memdata : wb_aluout;
    w_commit = wb_ctrl[CTRL_REGWRITE] && (wb_wreg != '0) && !reset;
  end

  regfile_2r1w u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (w_commit),
    .waddr  (wb_wreg),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (w_rf_rd1),
    .rdata2 (w_rf_rd2)
  );

`ifdef REGFILE_BYPASS_EN
  // Write-through: each port independently sees the value being committed
  always_comb begin
    rs1_data = (w_commit && (rs1_addr == wb_wreg)) ? wb_data : w_rf_rd1;
    rs2_data = (w_commit && (rs2_addr == wb_wreg)) ? wb_data : w_rf_rd2;
  end
`else
  // No bypass: reads return the array contents before this cycle's write
  always_comb begin
    rs1_data = w_rf_rd1;
    rs2_data = w_rf_rd2;
  end
`endif

  // Committed FIFO pointers, loaded only when the pointer-update bit is set
  always_ff @(posedge clk) begin
    if (reset) begin
      r_first <= '0;
      r_last  <= '0;
    end else if (wb_ctrl[CTRL_PTRUPD]) begin
      r_first <= first_in;
      r_last  <= last_in;
    end
  end

  // Retire counter: one per committed register write, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retire <= '0;
    end else if (w_commit) begin
      r_retire <= r_retire + 1'b1;
    end
  end

  assign fifo_first = r_first;
  assign fifo_last  = r_last;
  assign retire_cnt = r_retire;

endmodule : wb_regfile
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage of the five-stage pipeline. Consumes the MEM/WB pipeline register outputs: write register index, ALU result, 3-bit WB control and FIFO first/last pointers.
- Selects the write-back data and commits it to a 32x64 register file with 2 read ports and 1 write port, which serves ID-stage operand reads.
- Holds the committed FIFO first/last pointers and counts retired write-backs.

Parameters:
- DATA_W, 64, register/data width
- RADDR_W, 5, register index width (2^RADDR_W entries)
- PTR_W, 8, FIFO first/last pointer width
- CNT_W, 16, retire counter width

Ports:
- clk  in  1  single clock for all state
- reset  in  1  synchronous, active-high reset
- wb_wreg  in  RADDR_W  destination register index
- wb_aluout  in  DATA_W  ALU result from MEM/WB
- wb_memdata  in  DATA_W  load data from data memory
- wb_ctrl  in  3  [0] RegWrite, [1] MemToReg, [2] PtrUpdate
- first_in  in  PTR_W  FIFO first pointer from MEM/WB
- last_in  in  PTR_W  FIFO last pointer from MEM/WB
- rs1_addr  in  RADDR_W  read port 1 index (ID stage)
- rs2_addr  in  RADDR_W  read port 2 index (ID stage)
- rs1_data  out  DATA_W  read port 1 data, combinational
- rs2_data  out  DATA_W  read port 2 data, combinational
- wb_data  out  DATA_W  selected write-back value, combinational, for forwarding
- fifo_first  out  PTR_W  committed first pointer, registered
- fifo_last  out  PTR_W  committed last pointer, registered
- retire_cnt  out  CNT_W  count of committed register writes, registered

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, named reset.
- wb_data = wb_ctrl[1] ? wb_memdata : wb_aluout. Combinational, zero latency.
- Register write occurs at posedge clk when wb_ctrl[0]=1, wb_wreg!=0 and reset=0. The new value is visible in the array from the next cycle.
- r0 is hardwired to zero. Writes to index 0 are dropped and do not increment retire_cnt.
- Reads are combinational from the array; address 0 always returns 0.
- Pointer update: at posedge with wb_ctrl[2]=1, fifo_first<=first_in and fifo_last<=last_in. With wb_ctrl[2]=0 both hold.
- Pointer update is independent of RegWrite; both may occur in the same cycle.
- retire_cnt increments by 1 on each committed register write and wraps from 2^CNT_W-1 to 0.
- Reset at a posedge (takes priority over everything):
  - all 32 registers <= 0
  - fifo_first, fifo_last <= 0
  - retire_cnt <= 0
  - any write presented in that cycle is discarded
- Reset asserted mid-stream: state is cleared at the next edge. Outputs remain combinational functions of the cleared array from then on.
- Simultaneous read of the address being written in the same cycle is governed by the optional feature below.
- wb_ctrl = 3'b000 is a bubble: no state change.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass. If wb_ctrl[0]=1, wb_wreg!=0, reset=0 and rsN_addr==wb_wreg, then rsN_data = wb_data in that same cycle. Each port is decided independently.
- Not defined: reads return the pre-write array contents. ID-stage hazard handling must then stall one extra cycle.

Decomposition:
- Shared package holds:
  - width constants DATA_W, RADDR_W, PTR_W
  - WB control bit indices: CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_PTRUPD=2
  - localparam for the register count
- Natural sub-module: regfile_2r1w, the storage array with 2 combinational read ports, 1 synchronous write port, r0 masking and synchronous clear.
- The top level adds the write-back mux, optional bypass, pointer registers and retire counter.

Test Plan:
- Reset high 2 cycles, then read rs1=5, rs2=31 -> both return 0; fifo_first=fifo_last=0; retire_cnt=0.
- ctrl=001, wreg=5, aluout=0x1122334455667788, memdata=0xFFFF; next cycle rs1=5 -> 0x1122334455667788; retire_cnt=1.
- ctrl=011, wreg=7, memdata=0xDEADBEEF00000001 with rs2_addr=7 in the same cycle:
  - with bypass: rs2_data=0xDEADBEEF00000001 in that cycle
  - without bypass: rs2_data=0 in that cycle, then 0xDEADBEEF00000001 next cycle
- ctrl=001, wreg=0, aluout=0x55 -> rs1=0 reads 0; retire_cnt unchanged. ctrl=100, first_in=0x12, last_in=0x34 -> next cycle fifo_first=0x12, fifo_last=0x34; registers unchanged.
- Write r9=0xAB, then assert reset in the same cycle as ctrl=001, wreg=9, aluout=0xCD -> after the edge rs1=9 reads 0 and retire_cnt=0.
- Preload retire_cnt to 0xFFFF via 65535 writes, then one more write -> retire_cnt=0x0000.
